uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo.sv | 79 +++++++
 tb/tb_uart_rx_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive FIFO defaults
package uart_pkg;

    // Serial link timing
    localparam int CLK_FREQ_HZ  = 50_000_000;
    localparam int BAUD_RATE    = 9600;
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    // Receive FIFO defaults
    localparam int BYTESIZES_DEF   = 8;
    localparam int DEPTH_DEF       = 16;
    localparam int AFULL_LEVEL_DEF = 12;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO storage, pointers and word count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is left unreset; only the pointers define which words are live
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + P_ONE;
            if (rd_en) r_rd_ptr <= r_rd_ptr + P_ONE;
            if (wr_en && !rd_en)      r_count <= r_count + C_ONE;
            else if (!wr_en && rd_en) r_count <= r_count - C_ONE;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - buffers uart_rx words with edge-detected push, overrun and status flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int BYTESIZES   = BYTESIZES_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int AFULL_LEVEL = AFULL_LEVEL_DEF
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic [BYTESIZES-1:0]       rx_data,
    input  logic                       rx_ready,
    output logic [BYTESIZES-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL = CW'(AFULL_LEVEL);

    logic          r_rx_ready_d;
    logic          r_overrun;
    logic [CW-1:0] w_count;
    logic          w_push_evt;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;

    // History resets high so a ready level already present at reset release is not a new word
    always_ff @(posedge clock) begin
        if (!nreset) r_rx_ready_d <= 1'b1;
        else         r_rx_ready_d <= rx_ready;
    end

    assign w_push_evt = rx_ready && !r_rx_ready_d;
    assign w_full     = (w_count == C_DEPTH);
    assign w_empty    = (w_count == '0);
    assign w_pop      = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_wr_en    = w_push_evt && (!w_full || w_pop);
    assign w_drop     = w_push_evt && w_full && !w_pop;

    // Sticky loss flag; a new loss beats a coincident clear
    always_ff @(posedge clock) begin
        if (!nreset)          r_overrun <= 1'b0;
        else if (w_drop)      r_overrun <= 1'b1;
        else if (overrun_clr) r_overrun <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (BYTESIZES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .nreset  (nreset),
        .wr_en   (w_wr_en),
        .wr_data (rx_data),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .count   (w_count)
    );

    assign count       = w_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (w_count >= C_AFULL);
    assign out_valid   = !w_empty;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clock = 1'b0;
    logic       nreset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overrun;
    logic       overrun_clr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.BYTESIZES(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(exp_q.pop_front()));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        nreset = 1'b0; rx_data = 8'h00; rx_ready = 1'b1;
        out_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Release reset with ready already high: no push
        nreset = 1'b1;
        repeat (4) tick();
        chk("rel_count", 32'(count), 32'd0);
        chk("rel_empty", 32'(empty), 32'd1);

        // Long ready level gives exactly one word, visible the cycle after the edge
        rx_ready = 1'b0;
        tick();
        rx_data = 8'h78; rx_ready = 1'b1;
        tick();
        chk("lvl_valid", 32'(out_valid), 32'd1);
        chk("lvl_data", 32'(out_data), 32'h78);
        repeat (49) tick();
        chk("lvl_count", 32'(count), 32'd1);
        rx_ready = 1'b0;
        tick();
        exp_q.push_back(8'h78);
        drain_all();

        // Pop request while empty does nothing
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_empty_count", 32'(count), 32'd0);

        // Fill to 16; almost_full from the 12th word
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_afull", 32'(almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_overrun", 32'(overrun), 32'd0);

        // Overflow drops the word
        push(8'hAA);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_head", 32'(out_data), 32'h00);

        overrun_clr = 1'b1;
        tick();
        chk("clr_overrun", 32'(overrun), 32'd0);

        // Set beats coincident clear
        rx_data = 8'hAA; rx_ready = 1'b1;
        tick();
        chk("setclr_overrun", 32'(overrun), 32'd1);
        rx_ready = 1'b0;
        tick();
        chk("clr2_overrun", 32'(overrun), 32'd0);
        overrun_clr = 1'b0;

        // Push and pop together while full
        rx_data = 8'h55; rx_ready = 1'b1; out_ready = 1'b1;
        chk("pp_oldest", 32'(out_data), 32'h00);
        tick();
        rx_ready = 1'b0; out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        tick();
        for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h55);
        drain_all();

        // Reset mid-operation discards contents
        push(8'h11); push(8'h22); push(8'h33);
        chk("mid_count", 32'(count), 32'd3);
        nreset = 1'b0;
        tick();
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        nreset = 1'b1;
        tick();

        // Random bytes in two batches, drained in order
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) begin
                logic [7:0] v;
                v = 8'($urandom_range(0, 255));
                exp_q.push_back(v);
                push(v);
            end
            chk("rand_count", 32'(count), 32'd10);
            drain_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
